// File: rtl/magnitude_comparator_if.sv
// Operand/result bundle for magnitude_comparator: one operand pair in,
// one registered three-way flag set out.
interface magnitude_comparator_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] Data_in_A;
  logic [WIDTH-1:0] Data_in_B;
  logic             out_valid;
  logic             less;
  logic             equal;
  logic             greater;

  modport master (
    output in_valid, Data_in_A, Data_in_B,
    input  out_valid, less, equal, greater
  );

  modport slave (
    input  in_valid, Data_in_A, Data_in_B,
    output out_valid, less, equal, greater
  );
endinterface

// File: rtl/magnitude_comparator.sv
// Registered magnitude comparator: one result per valid operand pair,
// one-cycle latency, unsigned or two's-complement selected by SIGNED_MODE.
module magnitude_comparator #(
  parameter int WIDTH       = 4,
  parameter bit SIGNED_MODE = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  magnitude_comparator_if.slave bus
);

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic [WIDTH-1:0] bit_gt;
  logic [WIDTH-1:0] bit_lt;
  logic             gt_next;
  logic             lt_next;
  logic             eq_next;
  logic             out_valid_reg;
  logic             less_reg;
  logic             equal_reg;
  logic             greater_reg;

  // Inverting the sign bit maps two's-complement onto offset binary, so the
  // same unsigned compare below serves both modes.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (SIGNED_MODE && (gi == WIDTH - 1)) begin : g_sign
        assign a_key[gi] = ~bus.Data_in_A[gi];
        assign b_key[gi] = ~bus.Data_in_B[gi];
      end else begin : g_mag
        assign a_key[gi] = bus.Data_in_A[gi];
        assign b_key[gi] = bus.Data_in_B[gi];
      end
      assign bit_gt[gi] = a_key[gi] & ~b_key[gi];
      assign bit_lt[gi] = ~a_key[gi] & b_key[gi];
    end
  endgenerate

  // The most significant differing bit decides the result.
  always_comb begin
    gt_next = 1'b0;
    lt_next = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!gt_next && !lt_next) begin
        gt_next = bit_gt[i];
        lt_next = bit_lt[i];
      end
    end
    eq_next = ~(gt_next | lt_next);
  end

  // All-zero flags after reset mean "no result yet".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      less_reg      <= 1'b0;
      equal_reg     <= 1'b0;
      greater_reg   <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        less_reg    <= lt_next;
        equal_reg   <= eq_next;
        greater_reg <= gt_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.less      = less_reg;
  assign bus.equal     = equal_reg;
  assign bus.greater   = greater_reg;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Scoreboard bench: one unsigned and one signed comparator driven with the
// same operands, each result checked against an integer reference model.
module tb_magnitude_comparator;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   flags;   // {less, equal, greater}
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  magnitude_comparator_if #(.WIDTH(W)) if_u ();
  magnitude_comparator_if #(.WIDTH(W)) if_s ();

  magnitude_comparator #(.WIDTH(W), .SIGNED_MODE(1'b0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_u)
  );

  magnitude_comparator #(.WIDTH(W), .SIGNED_MODE(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  exp_t       exp_q[2][$];
  logic [2:0] last_flags[2];
  logic       rst_edge = 1'b0;
  logic       started  = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // Reference: turn operands into plain integers and compare them.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    int va;
    int vb;
    va = int'(a);
    vb = int'(b);
    if (sgn && a[W-1]) va = va - (1 << W);
    if (sgn && b[W-1]) vb = vb - (1 << W);
    return {va < vb, va == vb, va > vb};
  endfunction

  task automatic drive(input logic rn, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rn;
    if_u.in_valid  = v;
    if_u.Data_in_A = a;
    if_u.Data_in_B = b;
    if_s.in_valid  = v;
    if_s.Data_in_A = a;
    if_s.Data_in_B = b;
    if (rn && v) begin
      e.a = a;
      e.b = b;
      e.flags = ref_cmp(a, b, 1'b0);
      exp_q[0].push_back(e);
      e.flags = ref_cmp(a, b, 1'b1);
      exp_q[1].push_back(e);
    end
  endtask

  task automatic monitor_step(input int k, input logic ov, input logic [2:0] fl);
    string nm;
    exp_t  e;
    nm = (k == 0) ? "uns" : "sgn";
    checks++;
    if (rst_edge) begin
      if (ov !== 1'b0 || fl !== 3'b000) begin
        failures++;
        $display("FAIL %s reset: got out_valid=%b lt/eq/gt=%b, want out_valid=0 lt/eq/gt=000",
                 nm, ov, fl);
      end
      last_flags[k] = 3'b000;
    end else if (ov === 1'b1) begin
      if (exp_q[k].size() == 0) begin
        failures++;
        $display("FAIL %s spurious_result: got out_valid=1 lt/eq/gt=%b, want out_valid=0",
                 nm, fl);
      end else begin
        e = exp_q[k].pop_front();
        if (fl !== e.flags) begin
          failures++;
          $display("FAIL %s result a=%0h b=%0h: got lt/eq/gt=%b, want %b",
                   nm, e.a, e.b, fl, e.flags);
        end else begin
          $display("%s a=%0h b=%0h lt/eq/gt=%b", nm, e.a, e.b, fl);
        end
        last_flags[k] = e.flags;
      end
    end else begin
      if (ov !== 1'b0 || fl !== last_flags[k]) begin
        failures++;
        $display("FAIL %s hold: got out_valid=%b lt/eq/gt=%b, want out_valid=0 lt/eq/gt=%b",
                 nm, ov, fl, last_flags[k]);
      end
    end
  endtask

  always @(posedge clk) begin
    rst_edge <= ~rst_n;
    if (!rst_n) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      monitor_step(0, if_u.out_valid, {if_u.less, if_u.equal, if_u.greater});
      monitor_step(1, if_s.out_valid, {if_s.less, if_s.equal, if_s.greater});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_u.in_valid  = 1'b0;
    if_u.Data_in_A = '0;
    if_u.Data_in_B = '0;
    if_s.in_valid  = 1'b0;
    if_s.Data_in_A = '0;
    if_s.Data_in_B = '0;

    // Reset, including a valid that must be ignored.
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 4'd5, 4'd3);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 4'd7, 4'd1);

    // Directed cases, back-to-back.
    drive(1'b1, 1'b1, 4'd10, 4'd12);
    drive(1'b1, 1'b1, 4'd15, 4'd11);
    drive(1'b1, 1'b1, 4'd10, 4'd10);
    drive(1'b1, 1'b1, 4'b1111, 4'b0001);
    drive(1'b1, 1'b1, 4'b0111, 4'b1000);
    drive(1'b1, 1'b1, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 4'hF, 4'h0);

    // Hold with changing operands.
    drive(1'b1, 1'b1, 4'd3, 4'd5);
    repeat (3) drive(1'b1, 1'b0, W'($urandom), W'($urandom));

    // Reset mid-stream, then restart.
    drive(1'b1, 1'b1, 4'd9, 4'd2);
    drive(1'b0, 1'b1, W'($urandom), W'($urandom));
    drive(1'b1, 1'b1, 4'd0, 4'd0);
    drive(1'b1, 1'b0, W'($urandom), W'($urandom));

    // Exhaustive operand sweep.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        drive(1'b1, 1'b1, W'(a), W'(b));
      end
    end

    // Random traffic with gaps and occasional resets.
    repeat (300) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom));
    end

    repeat (3) drive(1'b1, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d: got %0d results outstanding, want 0", k, exp_q[k].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
